mbr_partition_parser: RTL and testbench
=======================================

Name: mbr_partition_parser

Overview:
- Sits directly downstream of the SD card controller's read byte stream. It consumes the 512-byte sector 0 (Master Boot Record) as it arrives and extracts the first FAT32 partition entry: type, start LBA and sector count.
- It also validates the 0x55AA boot signature.
- The FAT32 controller arms it before issuing the MBR read, then uses part_lba as the sector address of the volume boot record.

Parameters:
- BLOCK_BYTES, 512, bytes per sector; the byte counter wraps/ends here.
- TYPE_A, 8'h0B, first accepted partition type (FAT32 CHS).
- TYPE_B, 8'h0C, second accepted partition type (FAT32 LBA).

Ports:
- clk  in  1  system clock; all state updates on negedge clk, matching the SD byte stream timing.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms parser for a new sector.
- byte_in  in  8  incoming sector byte (SD incoming_byte).
- byte_valid  in  1  one-cycle strobe; byte_in is valid (SD finished_byte).
- block_done  in  1  one-cycle strobe; sector transfer ended (SD finished_block).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the result is final.
- valid  out  1  level; result registers hold a good FAT32 entry. Cleared on start.
- error  out  2  0 none, 1 bad signature, 2 no FAT32 entry, 3 short block. Held until next start.
- part_type  out  8  type byte of the selected entry.
- part_lba  out  32  start LBA of the selected entry.
- part_sectors  out  32  sector count of the selected entry.

Behaviour:
- Reset (async, immediate) forces the following, regardless of state, including mid-sector:
  - state IDLE
  - busy=0, done=0, valid=0, error=0
  - part_type=0, part_lba=0, part_sectors=0
  - byte counter=0, internal captures cleared
- State machine: IDLE -> COLLECT -> CHECK -> IDLE.
- IDLE:
  - start=1: clear valid/error/outputs/captures, counter=0, busy=1, go to COLLECT.
  - byte_valid/block_done while in IDLE are ignored.
- COLLECT:
  - Each byte_valid captures byte_in at offset = counter, then counter += 1 (10-bit).
  - Entry n (n=0..3) base = 0x1BE + 16n. Offset base+4 = type; base+8..11 = LBA; base+12..15 = sector count.
  - LBA and sector count are little-endian: byte k goes to bits [8k+7:8k].
  - Each entry's type, LBA and count are captured into a per-entry scratch set.
  - Offset 510 byte compared to 0x55, offset 511 to 0xAA; result latched as sig_ok.
  - Bytes with counter >= BLOCK_BYTES are ignored; the counter saturates and does not wrap.
  - block_done goes to CHECK.
  - byte_valid and block_done in the same cycle: the byte is captured first, then block_done is evaluated using the updated counter.
  - start while busy is ignored.
- CHECK (exactly one cycle):
  - Error priority:
    - counter < BLOCK_BYTES -> error=3.
    - else !sig_ok -> error=1.
    - else the lowest-numbered entry with type==TYPE_A or TYPE_B is selected -> drive part_type/part_lba/part_sectors, valid=1, error=0.
    - else error=2, outputs stay 0.
  - done=1 for this cycle; busy falls in the same cycle. Next state IDLE.
- Latency: done asserts on the clk edge following the block_done edge (1 cycle).
- Entries with type 0x00 or other values are skipped; their LBA is never reported.
- Outputs are stable from done until the next accepted start or reset.

Test Plan:
- Good MBR: start, 512 bytes where entry0 type=0x0C, LBA bytes 00 08 00 00, count bytes 00 F8 3F 00, sig 55 AA, then block_done -> one cycle later done=1, valid=1, error=0, part_type=0x0C, part_lba=0x00000800, part_sectors=0x003FF800, busy=0.
- Entry selection: entry0 type=0x07 (NTFS), entry1 type=0x0B with LBA 0x00002000, entry2 type=0x0C -> part_type=0x0B, part_lba=0x00002000.
- Bad signature: valid entry0 but bytes 510/511 = 55 00 -> error=1, valid=0, part_lba=0. All four entries type 0x00 with good signature -> error=2.
- Short/long block:
  - block_done after 300 bytes -> error=3.
  - 520 byte_valid strobes (extra bytes 0xFF) with a good sector first -> extra bytes ignored, valid=1, error=0.
  - Byte 511 and block_done in the same cycle -> signature accepted, valid=1.
- Reset mid-operation: assert reset after byte 200 -> busy=0, all outputs 0 immediately (async). A following start plus a good sector parses correctly.
- start pulsed again at byte 100 -> ignored; the result reflects the original sector. byte_valid in IDLE -> no output change.

Source files
------------

// File: rtl/mbr_partition_parser.sv
// Extracts the first FAT32 partition entry and checks the 0x55AA signature of a streamed MBR sector.
// Latency: done one clk after block_done. Backpressure: none, a byte is taken on every byte_valid strobe.
module mbr_partition_parser #(
    parameter int         BLOCK_BYTES = 512,
    parameter logic [7:0] TYPE_A      = 8'h0B,
    parameter logic [7:0] TYPE_B      = 8'h0C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        block_done,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [1:0]  error,
    output logic [7:0]  part_type,
    output logic [31:0] part_lba,
    output logic [31:0] part_sectors
);

    typedef struct packed {
        logic [7:0]  ptype;
        logic [31:0] lba;
        logic [31:0] sectors;
    } entry_t;

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    localparam logic [9:0] TABLE_BASE = 10'h1BE;
    localparam logic [9:0] TABLE_END  = 10'h1FE;
    localparam logic [9:0] BLOCK_CNT  = 10'(BLOCK_BYTES);
    localparam logic [9:0] SIG_LO     = 10'(BLOCK_BYTES - 2);
    localparam logic [9:0] SIG_HI     = 10'(BLOCK_BYTES - 1);

    state_t     state;
    logic [9:0] byte_cnt;
    entry_t     entries [4];
    logic       sig_lo_ok;
    logic       sig_hi_ok;

    logic       take_byte;
    logic       in_table;
    logic [5:0] table_rel;
    logic [1:0] ent_idx;
    logic [3:0] ent_off;
    logic       sel_found;
    logic [1:0] sel_idx;

    always_comb begin
        take_byte = byte_valid && (byte_cnt < BLOCK_CNT);
        in_table  = (byte_cnt >= TABLE_BASE) && (byte_cnt < TABLE_END);
        table_rel = 6'(byte_cnt - TABLE_BASE);
        ent_idx   = table_rel[5:4];
        ent_off   = table_rel[3:0];
    end

    // Scanning downwards leaves the lowest-numbered FAT32 entry selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (entries[i].ptype == TYPE_A || entries[i].ptype == TYPE_B) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            valid        <= 1'b0;
            error        <= 2'd0;
            part_type    <= 8'd0;
            part_lba     <= 32'd0;
            part_sectors <= 32'd0;
            byte_cnt     <= 10'd0;
            sig_lo_ok    <= 1'b0;
            sig_hi_ok    <= 1'b0;
            for (int i = 0; i < 4; i++) entries[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= COLLECT;
                        busy         <= 1'b1;
                        valid        <= 1'b0;
                        error        <= 2'd0;
                        part_type    <= 8'd0;
                        part_lba     <= 32'd0;
                        part_sectors <= 32'd0;
                        byte_cnt     <= 10'd0;
                        sig_lo_ok    <= 1'b0;
                        sig_hi_ok    <= 1'b0;
                        for (int i = 0; i < 4; i++) entries[i] <= '0;
                    end
                end
                COLLECT: begin
                    if (take_byte) begin
                        byte_cnt <= byte_cnt + 10'd1;
                        if (in_table) begin
                            // Multi-byte fields are little-endian: field byte k lands at bits [8k+7:8k].
                            case (ent_off)
                                4'd4:                      entries[ent_idx].ptype <= byte_in;
                                4'd8, 4'd9, 4'd10, 4'd11:  entries[ent_idx].lba[{ent_off[1:0], 3'b000} +: 8] <= byte_in;
                                4'd12, 4'd13, 4'd14, 4'd15: entries[ent_idx].sectors[{ent_off[1:0], 3'b000} +: 8] <= byte_in;
                                default: ;
                            endcase
                        end
                        if (byte_cnt == SIG_LO) sig_lo_ok <= (byte_in == 8'h55);
                        if (byte_cnt == SIG_HI) sig_hi_ok <= (byte_in == 8'hAA);
                    end
                    if (block_done) state <= CHECK;
                end
                CHECK: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (byte_cnt < BLOCK_CNT) begin
                        error <= 2'd3;
                    end else if (!(sig_lo_ok && sig_hi_ok)) begin
                        error <= 2'd1;
                    end else if (sel_found) begin
                        valid        <= 1'b1;
                        error        <= 2'd0;
                        part_type    <= entries[sel_idx].ptype;
                        part_lba     <= entries[sel_idx].lba;
                        part_sectors <= entries[sel_idx].sectors;
                    end else begin
                        error <= 2'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbr_partition_parser.sv
// Directed and randomized MBR sectors checked against a byte-array reference of the partition table rules.
module tb_mbr_partition_parser;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        block_done;
    logic        busy;
    logic        done;
    logic        valid;
    logic [1:0]  error;
    logic [7:0]  part_type;
    logic [31:0] part_lba;
    logic [31:0] part_sectors;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  sec [0:519];
    logic        exp_valid;
    logic [1:0]  exp_err;
    logic [7:0]  exp_type;
    logic [31:0] exp_lba;
    logic [31:0] exp_cnt;

    mbr_partition_parser dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .block_done(block_done), .busy(busy),
        .done(done), .valid(valid), .error(error), .part_type(part_type),
        .part_lba(part_lba), .part_sectors(part_sectors)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; the DUT samples on the falling edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic bd, input logic st);
        @(posedge clk);
        byte_valid = v;
        byte_in    = b;
        block_done = bd;
        start      = st;
    endtask

    task automatic fill_base();
        for (int i = 0; i < 520; i++) sec[i] = 8'($urandom);
        for (int e = 0; e < 4; e++) sec[446 + 16 * e + 4] = 8'h00;
        sec[510] = 8'h55;
        sec[511] = 8'hAA;
    endtask

    task automatic set_entry(input int e, input logic [7:0] t, input logic [31:0] lba, input logic [31:0] cnt);
        sec[446 + 16 * e + 4] = t;
        for (int k = 0; k < 4; k++) begin
            sec[446 + 16 * e + 8 + k]  = lba[8 * k +: 8];
            sec[446 + 16 * e + 12 + k] = cnt[8 * k +: 8];
        end
    endtask

    function automatic void model(input int nb);
        int base;
        bit found;
        exp_valid = 1'b0;
        exp_err   = 2'd0;
        exp_type  = 8'd0;
        exp_lba   = 32'd0;
        exp_cnt   = 32'd0;
        found     = 1'b0;
        if (nb < 512) exp_err = 2'd3;
        else if (sec[510] != 8'h55 || sec[511] != 8'hAA) exp_err = 2'd1;
        else begin
            for (int e = 0; e < 4; e++) begin
                base = 446 + 16 * e;
                if (!found && (sec[base + 4] == 8'h0B || sec[base + 4] == 8'h0C)) begin
                    found     = 1'b1;
                    exp_type  = sec[base + 4];
                    exp_lba   = {sec[base + 11], sec[base + 10], sec[base + 9], sec[base + 8]};
                    exp_cnt   = {sec[base + 15], sec[base + 14], sec[base + 13], sec[base + 12]};
                end
            end
            if (found) exp_valid = 1'b1;
            else exp_err = 2'd2;
        end
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, ".valid"}, 32'(valid), 32'(exp_valid));
        chk({tag, ".error"}, 32'(error), 32'(exp_err));
        chk({tag, ".type"}, 32'(part_type), 32'(exp_type));
        chk({tag, ".lba"}, part_lba, exp_lba);
        chk({tag, ".sectors"}, part_sectors, exp_cnt);
    endtask

    // Streams nb bytes of sec[], optionally merging block_done with the last byte,
    // re-pulsing start at byte restart_at, with up to max_gap idle cycles between bytes.
    task automatic run_sector(input string tag, input int nb, input bit bd_last,
                              input int restart_at, input int max_gap);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 0);
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        chk({tag, ".valid_clr"}, 32'(valid), 32'd0);
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, max_gap)) cyc(0, 8'h00, 0, 0);
            cyc(1, sec[i], bd_last && (i == nb - 1), i == restart_at);
        end
        if (!bd_last) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        cyc(0, 8'h00, 0, 0);
        model(nb);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk_outputs(tag);
        cyc(0, 8'h00, 0, 0);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk_outputs({tag, ".hold"});
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; start = 1'b0; byte_in = 8'h00;
        byte_valid = 1'b0; block_done = 1'b0;
        #1 reset = 1'b1;
        #2;
        model(0);
        exp_err = 2'd0;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_outputs("reset");
        @(posedge clk);
        reset = 1'b0;

        // Good MBR, entry0 FAT32 LBA
        fill_base();
        set_entry(0, 8'h0C, 32'h0000_0800, 32'h003F_F800);
        run_sector("good", 512, 0, -1, 0);
        chk("good.lba_const", part_lba, 32'h0000_0800);
        chk("good.sectors_const", part_sectors, 32'h003F_F800);

        // byte_valid / block_done in IDLE change nothing
        for (int i = 0; i < 5; i++) cyc(1, 8'hAA, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);
        chk_outputs("idle");

        // Lowest-numbered FAT32 entry wins over NTFS and later FAT32
        fill_base();
        set_entry(0, 8'h07, 32'h1111_1111, 32'h2222_2222);
        set_entry(1, 8'h0B, 32'h0000_2000, 32'h0001_0000);
        set_entry(2, 8'h0C, 32'h0000_9000, 32'h0000_0100);
        run_sector("select", 512, 0, -1, 1);
        chk("select.lba_const", part_lba, 32'h0000_2000);

        fill_base();
        set_entry(0, 8'h0C, 32'h0000_0800, 32'h0000_1000);
        sec[511] = 8'h00;
        run_sector("badsig", 512, 0, -1, 0);

        fill_base();
        run_sector("noentry", 512, 0, -1, 0);

        fill_base();
        set_entry(0, 8'h0B, 32'h0000_0040, 32'h0000_0080);
        run_sector("short", 300, 0, -1, 0);

        fill_base();
        set_entry(3, 8'h0C, 32'hDEAD_0001, 32'h0BAD_F00D);
        for (int i = 512; i < 520; i++) sec[i] = 8'hFF;
        run_sector("long", 520, 0, -1, 0);

        fill_base();
        set_entry(1, 8'h0C, 32'h0000_3000, 32'h0000_4000);
        run_sector("merged_bd", 512, 1, -1, 0);

        // Async reset partway through a sector
        fill_base();
        set_entry(0, 8'h0B, 32'h0000_5000, 32'h0000_6000);
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 200; i++) cyc(1, sec[i], 0, 0);
        @(posedge clk);
        byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model(0);
        exp_err = 2'd0;
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.done", 32'(done), 32'd0);
        chk_outputs("midreset");
        @(posedge clk);
        reset = 1'b0;
        run_sector("after_reset", 512, 0, -1, 0);

        fill_base();
        set_entry(2, 8'h0B, 32'h0000_7000, 32'h0000_8000);
        run_sector("restart_ignored", 512, 0, 100, 0);

        // Randomized sectors
        for (int t = 0; t < 24; t++) begin
            logic [7:0] types [6];
            int nb;
            types = '{8'h00, 8'h07, 8'h0B, 8'h0C, 8'h83, 8'($urandom)};
            fill_base();
            for (int e = 0; e < 4; e++) sec[446 + 16 * e + 4] = types[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) sec[510 + $urandom_range(0, 1)] = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       nb = $urandom_range(100, 511);
                1:       nb = $urandom_range(513, 520);
                default: nb = 512;
            endcase
            run_sector("rand", nb, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
